// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4x1 mux channel, with a one-cycle gap between owners.
// Define ARB_TIMEOUT_EN to preempt an owner after HOLD_MAX cycles when others are waiting.
module mux4_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       preempt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_GAP
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] idx;
   logic [1:0] win;
   logic       found;

   if (HOLD_MAX < 1) begin : g_bad_hold
      $error("mux4_rr_arbiter: HOLD_MAX must be >= 1");
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(HOLD_MAX + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          preempt_q, preempt_d;
   logic          at_max;
   logic          others;

   assign at_max = (cnt_q == CW'(HOLD_MAX));
   assign others = |(req & ~(4'b0001 << sel_q));
`endif

   // Scan downward so the lowest offset from ptr overwrites and wins.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      idx   = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr_q + 2'(k);
         if (req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
`endif
      unique case (state_q)
         S_IDLE, S_GAP: begin
            gnt_d   = 4'b0000;
            state_d = S_IDLE;
            if (found) begin
               state_d = S_GRANT;
               gnt_d   = 4'b0001 << win;
               sel_d   = win;
               ptr_d   = win + 2'd1;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = CW'(1);
`endif
            end
         end
         S_GRANT: begin
            if (!req[sel_q]) begin
               state_d = S_GAP;
               gnt_d   = 4'b0000;
            end
`ifdef ARB_TIMEOUT_EN
            else if (at_max && others) begin
               state_d   = S_GAP;
               gnt_d     = 4'b0000;
               preempt_d = 1'b1;
            end else if (!at_max) begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'b00;
         ptr_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         preempt_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
      end
   end

   assign preempt = preempt_q;
`else
   assign preempt = 1'b0;
`endif

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = (state_q == S_GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized and directed bench for mux4_rr_arbiter against a behavioural owner/pointer model.
// Timeout expectations follow ARB_TIMEOUT_EN with HOLD_MAX=4.
module tb_mux4_rr_arbiter;

   localparam int HM = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO = 1'b1;
`else
   localparam bit TO = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       preempt;

   int n_tests = 0;
   int n_fail  = 0;

   mux4_rr_arbiter #(.HOLD_MAX(HM)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .sel     (sel),
      .busy    (busy),
      .preempt (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: phase 0 idle, 1 owned, 2 gap; owner doubles as last owner
   int m_phase, m_owner, m_ptr, m_hold;
   bit m_pre;
   int pick;

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   always_comb pick = rr_pick(req, m_ptr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_owner <= 0;
         m_ptr   <= 0;
         m_hold  <= 0;
         m_pre   <= 1'b0;
      end else begin
         m_pre <= 1'b0;
         if (m_phase == 1) begin
            if (!req[m_owner])
               m_phase <= 2;
            else if (TO && m_hold >= HM && (req & ~(4'b0001 << m_owner)) != 4'b0000) begin
               m_phase <= 2;
               m_pre   <= 1'b1;
            end else
               m_hold <= (m_hold < HM) ? m_hold + 1 : HM;
         end else if (pick >= 0) begin
            m_phase <= 1;
            m_owner <= pick;
            m_ptr   <= (pick + 1) % 4;
            m_hold  <= 1;
         end else
            m_phase <= 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_gnt", gnt, (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
         chk("m_sel", sel, m_owner);
         chk("m_busy", busy, (m_phase == 1));
         chk("m_pre", preempt, m_pre);
         chk("inv_onehot", $onehot0(gnt), 1);
         chk("inv_busy", busy, (gnt != 4'b0000));
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      repeat (3) cyc();
      chk("rst_gnt", gnt, 0);
      chk("rst_sel", sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pre", preempt, 0);
      rst_n = 1'b1;
      cyc();
      req = 4'hF;
      cyc();
      for (int i = 0; i < 4; i++) begin
         chk("rot_gnt", gnt, 32'd1 << i);
         req = (i == 3) ? 4'b0101 : (4'hF & ~(4'b0001 << i));
         cyc();
         chk("rot_gap_gnt", gnt, 0);
         chk("rot_gap_sel", sel, i);
         if (i < 3) req = 4'hF;
         cyc();
      end
      chk("wrap_gnt", gnt, 4'b0001);
      req = 4'b0100;
      cyc();
      req = 4'b0101;
      cyc();
      chk("skip_gnt", gnt, 4'b0100);
      req = 4'b0000;
      cyc();
      cyc();
      req = 4'b0100;
      cyc();
      chk("single_gnt", gnt, 4'b0100);
      chk("single_sel", sel, 2);
      chk("single_busy", busy, 1);
      req = 4'b0000;
      cyc();
      chk("single_gap_gnt", gnt, 0);
      chk("single_gap_sel", sel, 2);
      cyc();
      chk("single_idle_busy", busy, 0);
      req = 4'b0011;
      repeat (4) begin
         cyc();
         chk("to_hold", gnt, 4'b0001);
      end
`ifdef ARB_TIMEOUT_EN
      cyc();
      chk("to_pre", preempt, 1);
      chk("to_gap", gnt, 0);
      cyc();
      chk("to_next", gnt, 4'b0010);
      chk("to_pre_off", preempt, 0);
`else
      repeat (20) begin
         cyc();
         chk("noto_hold", gnt, 4'b0001);
         chk("noto_pre", preempt, 0);
      end
`endif
      req = 4'b0000;
      cyc();
      cyc();
      req = 4'b0001;
      repeat (22) begin
         cyc();
         chk("solo_hold", gnt, 4'b0001);
         chk("solo_pre", preempt, 0);
      end
      req = 4'b0000;
      cyc();
      cyc();
      repeat (800) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         cyc();
      end
      req = 4'hF;
      cyc();
      cyc();
      cyc();
      chk("mid_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_gnt", gnt, 0);
      chk("async_sel", sel, 0);
      chk("async_busy", busy, 0);
      chk("async_pre", preempt, 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      chk("post_rst_gnt", gnt, 4'b0001);
      req = 4'b0000;
      cyc();
      cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
